countdown_display: RTL

//  Downstream consumer of the minute/second countdown timer. Converts minute
//  (7b) and second (6b) to BCD with a sequential double-dabble, then drives a
//  4-digit multiplexed common-anode 7-segment display as MM.SS. Flags expiry
//  (00:00) and blinks the display on expiry and the DP while paused.

---
 rtl/countdown_display.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/countdown_display.sv
// MM.SS countdown display: sequential double-dabble BCD conversion feeding a
// 4-digit multiplexed common-anode 7-segment scanner with expiry/pause blink.
module countdown_display #(
    parameter int SCAN_DIV  = 4000,
    parameter int BLINK_DIV = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] minute,
    input  logic [5:0] second,
    input  logic       pause,
    output logic [3:0] digit_sel,
    output logic [6:0] seg,
    output logic       dp,
    output logic       expired
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV_MIN, CONV_SEC, UPDATE} state_t;

    logic [SW-1:0] r_scan_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_ph;
    logic          w_scan_tick;
    logic          w_blink_tick;

    assign w_scan_tick  = (r_scan_cnt  == SW'(SCAN_DIV - 1));
    assign w_blink_tick = (r_blink_cnt == BW'(BLINK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else begin
            r_scan_cnt  <= w_scan_tick  ? '0 : r_scan_cnt  + 1'b1;
            r_blink_cnt <= w_blink_tick ? '0 : r_blink_cnt + 1'b1;
            if (w_blink_tick)
                r_blink_ph <= ~r_blink_ph;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            expired <= 1'b0;
        else
            expired <= (minute == 7'd0) && (second == 6'd0);
    end

    // Clamp before conversion so the BCD never exceeds two decimal digits.
    logic [6:0] w_min_c;
    logic [5:0] w_sec_c;
    assign w_min_c = (minute > 7'd99) ? 7'd99 : minute;
    assign w_sec_c = (second > 6'd59) ? 6'd59 : second;

    // Shift register {tens, ones, binary}; one add-3 + shift per cycle.
    state_t      r_state;
    logic [14:0] r_sr;
    logic [2:0]  r_bit;
    logic [5:0]  r_sec_lat;
    logic [7:0]  r_min_bcd, r_sec_bcd;
    logic [7:0]  r_d_min, r_d_sec;
    logic        r_valid;
    logic [14:0] w_adj, w_shift;

    always_comb begin
        w_adj = r_sr;
        if (r_sr[14:11] >= 4'd5) w_adj[14:11] = r_sr[14:11] + 4'd3;
        if (r_sr[10:7]  >= 4'd5) w_adj[10:7]  = r_sr[10:7]  + 4'd3;
        w_shift = {w_adj[13:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sr      <= '0;
            r_bit     <= '0;
            r_sec_lat <= '0;
            r_min_bcd <= '0;
            r_sec_bcd <= '0;
            r_d_min   <= '0;
            r_d_sec   <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_scan_tick) begin
                    r_sr      <= {8'd0, w_min_c};
                    r_sec_lat <= w_sec_c;
                    r_bit     <= '0;
                    r_state   <= CONV_MIN;
                end
                CONV_MIN: begin
                    r_sr  <= w_shift;
                    r_bit <= r_bit + 3'd1;
                    if (r_bit == 3'd6) begin
                        r_min_bcd <= w_shift[14:7];
                        r_sr      <= {8'd0, 1'b0, r_sec_lat};
                        r_bit     <= '0;
                        r_state   <= CONV_SEC;
                    end
                end
                CONV_SEC: begin
                    r_sr  <= w_shift;
                    r_bit <= r_bit + 3'd1;
                    if (r_bit == 3'd6) begin
                        r_sec_bcd <= w_shift[14:7];
                        r_bit     <= '0;
                        r_state   <= UPDATE;
                    end
                end
                default: begin
                    r_d_min <= r_min_bcd;
                    r_d_sec <= r_sec_bcd;
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    logic [1:0] r_idx;
    logic [1:0] w_idx_nxt;
    logic [3:0] w_dig;
    logic [6:0] w_seg_raw;
    logic       w_blank_exp;
    logic [6:0] w_seg_nxt;
    logic       w_dp_nxt;

    assign w_idx_nxt   = r_idx + 2'd1;
    assign w_blank_exp = expired && r_blink_ph;

    always_comb begin
        case (w_idx_nxt)
            2'd3:    w_dig = r_d_min[7:4];
            2'd2:    w_dig = r_d_min[3:0];
            2'd1:    w_dig = r_d_sec[7:4];
            default: w_dig = r_d_sec[3:0];
        endcase
        case (w_dig)
            4'd0:    w_seg_raw = 7'h40;
            4'd1:    w_seg_raw = 7'h79;
            4'd2:    w_seg_raw = 7'h24;
            4'd3:    w_seg_raw = 7'h30;
            4'd4:    w_seg_raw = 7'h19;
            4'd5:    w_seg_raw = 7'h12;
            4'd6:    w_seg_raw = 7'h02;
            4'd7:    w_seg_raw = 7'h78;
            4'd8:    w_seg_raw = 7'h00;
            default: w_seg_raw = 7'h10;
        endcase
        w_seg_nxt = (w_blank_exp || (w_idx_nxt == 2'd3 && w_dig == 4'd0)) ? 7'h7F : w_seg_raw;
        w_dp_nxt  = !((w_idx_nxt == 2'd2) && !w_blank_exp && !(pause && r_blink_ph));
    end

    // Display stays dark until the first full conversion has landed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            digit_sel <= 4'hF;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else if (w_scan_tick) begin
            r_idx <= w_idx_nxt;
            if (r_valid) begin
                digit_sel <= ~(4'b0001 << w_idx_nxt);
                seg       <= w_seg_nxt;
                dp        <= w_dp_nxt;
            end else begin
                digit_sel <= 4'hF;
                seg       <= 7'h7F;
                dp        <= 1'b1;
            end
        end
    end

endmodule
